// File: rtl/autoconfig_ctrl.sv
// autoconfig_ctrl -- Zorro AutoConfig chain sequencer for the on-chip boards.
// Serves CPU accesses to the $E8xxxx window from the synchronous nibble ROM,
// latches base-address and shut-up writes, and walks the enabled board slots
// (0=ZII RAM, 1=ZIII RAM, 2=ETH, 3=null terminator).
// Optional feature macro: AUTOCONFIG_ETH_EN -- when defined, slot 2 (Ethernet)
// participates according to eth_en; otherwise slot 2 is always skipped and
// eth_base/eth_cfg are tied to zero.
module autoconfig_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        zii_en,
    input  logic        ziii_en,
    input  logic        eth_en,
    input  logic        req,
    input  logic        sel,
    input  logic        rw,
    input  logic [6:0]  addr,
    input  logic [7:0]  wdata,
    output logic        ack,
    output logic [15:0] rdata,
    output logic [7:0]  rom_a,
    input  logic [3:0]  rom_q,
    output logic [7:0]  zii_base,
    output logic [15:0] ziii_base,
    output logic [15:0] eth_base,
    output logic        zii_cfg,
    output logic        ziii_cfg,
    output logic        eth_cfg,
    output logic        cfg_done
);

    // Register offsets expressed as CPU A[7:1].
    localparam logic [6:0] OFS_Z3_HI  = 7'h22;  // $44
    localparam logic [6:0] OFS_Z3_LO  = 7'h23;  // $46
    localparam logic [6:0] OFS_Z2_HI  = 7'h24;  // $48
    localparam logic [6:0] OFS_Z2_LO  = 7'h25;  // $4A
    localparam logic [6:0] OFS_SHUTUP = 7'h26;  // $4C

    typedef enum logic [1:0] {
        IDLE,
        RD0,
        RD1,
        WAIT_REL
    } state_t;

    state_t     state;
    logic [1:0] brd;
    logic       init_done;
    logic       zii_en_q;
    logic       ziii_en_q;
    logic [2:0] en_eff;
    logic [1:0] brd_first;
    logic [1:0] brd_next;

    logic       wr_fire;
    logic       adv;
    logic       zii_lo_we;
    logic       zii_hi_we;
    logic       ziii_lo_we;
    logic       ziii_hi_we;

`ifdef AUTOCONFIG_ETH_EN
    logic       eth_en_q;
    logic       eth_lo_we;
    logic       eth_hi_we;
    assign en_eff = {eth_en_q, ziii_en_q, zii_en_q};
`else
    logic       unused_eth_en;
    assign unused_eth_en = eth_en;
    assign en_eff        = {1'b0, ziii_en_q, zii_en_q};
    assign eth_base      = 16'h0000;
    assign eth_cfg       = 1'b0;
`endif

    assign rom_a    = {brd, addr[6:1]};
    assign cfg_done = init_done && (brd == 2'd3);

    // Board enables are sampled only while reset is held, frozen afterwards.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            zii_en_q  <= zii_en;
            ziii_en_q <= ziii_en;
`ifdef AUTOCONFIG_ETH_EN
            eth_en_q  <= eth_en;
`endif
        end
    end

    // First enabled slot after reset, and the next enabled slot above brd.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        brd_first = 2'd3;
        if (en_eff[2]) brd_first = 2'd2;
        if (en_eff[1]) brd_first = 2'd1;
        if (en_eff[0]) brd_first = 2'd0;

        brd_next = 2'd3;
        case (brd)
            2'd0: begin
                if (en_eff[1])      brd_next = 2'd1;
                else if (en_eff[2]) brd_next = 2'd2;
            end
            2'd1: begin
                if (en_eff[2]) brd_next = 2'd2;
            end
            default: brd_next = 2'd3;
        endcase
    end

    // Decode an accepted write into per-register strobes and a chain advance.
    always_comb begin
        wr_fire    = init_done && (state == IDLE) && req && sel && !rw;
        adv        = 1'b0;
        zii_lo_we  = 1'b0;
        zii_hi_we  = 1'b0;
        ziii_lo_we = 1'b0;
        ziii_hi_we = 1'b0;
`ifdef AUTOCONFIG_ETH_EN
        eth_lo_we  = 1'b0;
        eth_hi_we  = 1'b0;
`endif
        if (wr_fire) begin
            case (brd)
                2'd0: begin
                    zii_lo_we = (addr == OFS_Z2_LO);
                    zii_hi_we = (addr == OFS_Z2_HI);
                    adv       = (addr == OFS_Z2_HI) || (addr == OFS_SHUTUP);
                end
                2'd1: begin
                    ziii_lo_we = (addr == OFS_Z3_LO);
                    ziii_hi_we = (addr == OFS_Z3_HI);
                    adv        = (addr == OFS_Z3_HI) || (addr == OFS_SHUTUP);
                end
`ifdef AUTOCONFIG_ETH_EN
                2'd2: begin
                    eth_lo_we = (addr == OFS_Z3_LO);
                    eth_hi_we = (addr == OFS_Z3_HI);
                    adv       = (addr == OFS_Z3_HI) || (addr == OFS_SHUTUP);
                end
`endif
                default: adv = 1'b0;
            endcase
        end
    end

    // Bus FSM: read pipeline through the ROM, write ack, release wait; board pointer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state     <= IDLE;
            ack       <= 1'b0;
            rdata     <= 16'hFFFF;
            brd       <= 2'd0;
            init_done <= 1'b0;
        end else begin
            ack <= 1'b0;

            if (!init_done) begin
                init_done <= 1'b1;
                brd       <= brd_first;
            end else if (adv) begin
                brd <= brd_next;
            end

            case (state)
                IDLE: begin
                    if (init_done && req && sel) begin
                        if (rw) begin
                            state <= RD0;
                        end else begin
                            ack   <= 1'b1;
                            state <= WAIT_REL;
                        end
                    end
                end
                RD0: state <= RD1;
                RD1: begin
                    rdata <= {rom_q, 12'hFFF};
                    ack   <= 1'b1;
                    state <= WAIT_REL;
                end
                WAIT_REL: begin
                    if (!req) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ZII and ZIII base registers and sticky configured flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            zii_base  <= 8'h00;
            ziii_base <= 16'h0000;
            zii_cfg   <= 1'b0;
            ziii_cfg  <= 1'b0;
        end else begin
            if (zii_lo_we) zii_base[3:0] <= wdata[7:4];
            if (zii_hi_we) begin
                zii_base[7:4] <= wdata[7:4];
                zii_cfg       <= 1'b1;
            end
            if (ziii_lo_we) ziii_base[7:0] <= wdata;
            if (ziii_hi_we) begin
                ziii_base[15:8] <= wdata;
                ziii_cfg        <= 1'b1;
            end
        end
    end

`ifdef AUTOCONFIG_ETH_EN
    // Ethernet base register and sticky configured flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            eth_base <= 16'h0000;
            eth_cfg  <= 1'b0;
        end else begin
            if (eth_lo_we) eth_base[7:0] <= wdata;
            if (eth_hi_we) begin
                eth_base[15:8] <= wdata;
                eth_cfg        <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_autoconfig_ctrl.sv
// Testbench for autoconfig_ctrl: directed vector table, hand-written
// multi-cycle corner cases, and randomized traffic against a slot-level model.
module tb_autoconfig_ctrl;

`ifdef AUTOCONFIG_ETH_EN
    localparam bit ETH_BUILD = 1'b1;
`else
    localparam bit ETH_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        zii_en, ziii_en, eth_en;
    logic        req, sel, rw;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic        ack;
    logic [15:0] rdata;
    logic [7:0]  rom_a;
    logic [3:0]  rom_q;
    logic [7:0]  zii_base;
    logic [15:0] ziii_base, eth_base;
    logic        zii_cfg, ziii_cfg, eth_cfg, cfg_done;

    int n_cmp = 0;
    int n_bad = 0;

    autoconfig_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .zii_en(zii_en), .ziii_en(ziii_en), .eth_en(eth_en),
        .req(req), .sel(sel), .rw(rw), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .rom_a(rom_a), .rom_q(rom_q),
        .zii_base(zii_base), .ziii_base(ziii_base), .eth_base(eth_base),
        .zii_cfg(zii_cfg), .ziii_cfg(ziii_cfg), .eth_cfg(eth_cfg),
        .cfg_done(cfg_done)
    );

    always #5 clk = ~clk;

    // Nibble ROM contents; address 0 of board 0 holds 4'b1110.
    function automatic logic [3:0] rom_fn(input logic [7:0] a);
        return a[7:4] ^ a[3:0] ^ 4'hE;
    endfunction

    // Synchronous ROM: data valid one clock after the address.
    always @(posedge clk) rom_q <= rom_fn(rom_a);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model (slot level) ----------------
    bit          m_en[3];
    int          m_brd;
    logic [15:0] m_base[3];
    bit          m_cfg[3];
    logic [15:0] m_rdata;

    task automatic model_advance();
        int s;
        s = m_brd + 1;
        while (s < 3 && !m_en[s]) s++;
        m_brd = s;
    endtask

    task automatic model_write(input logic [7:0] off, input logic [7:0] wd);
        if (m_brd == 3) return;
        if (off == 8'h4C) begin
            model_advance();
        end else if (m_brd == 0) begin
            if (off == 8'h4A) m_base[0][3:0] = wd[7:4];
            else if (off == 8'h48) begin
                m_base[0][7:4] = wd[7:4];
                m_cfg[0] = 1'b1;
                model_advance();
            end
        end else begin
            if (off == 8'h44) begin
                m_base[m_brd][15:8] = wd;
                m_cfg[m_brd] = 1'b1;
                model_advance();
            end else if (off == 8'h46) begin
                m_base[m_brd][7:0] = wd;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_zii_base"},  32'(zii_base),  32'(m_base[0][7:0]));
        check({tag, "_ziii_base"}, 32'(ziii_base), 32'(m_base[1]));
        check({tag, "_eth_base"},  32'(eth_base),  32'(m_base[2]));
        check({tag, "_cfg"}, 32'({eth_cfg, ziii_cfg, zii_cfg}), 32'({m_cfg[2], m_cfg[1], m_cfg[0]}));
        check({tag, "_cfg_done"}, 32'(cfg_done), 32'(m_brd == 3));
        check({tag, "_rom_a"}, 32'(rom_a), 32'({2'(m_brd), addr[6:1]}));
        check({tag, "_rdata"}, 32'(rdata), 32'(m_rdata));
    endtask

    // ---------------- bus helpers (inputs change on negedge) ----------------
    task automatic do_reset(input bit e0, input bit e1, input bit e2);
        reset_n = 1'b0; req = 1'b0; sel = 1'b1; rw = 1'b1; addr = 7'h00; wdata = 8'h00;
        zii_en = e0; ziii_en = e1; eth_en = e2;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_rdata", 32'(rdata), 32'hFFFF);
        check("rst_cfg_done", 32'(cfg_done), 32'h0);
        reset_n = 1'b1;
        // Enables must be ignored once reset is released.
        zii_en = 1'($urandom); ziii_en = 1'($urandom); eth_en = 1'($urandom);
        @(posedge clk);
        @(negedge clk);
        m_en[0] = e0; m_en[1] = e1; m_en[2] = e2 && ETH_BUILD;
        m_brd = 0;
        while (m_brd < 3 && !m_en[m_brd]) m_brd++;
        for (int i = 0; i < 3; i++) begin
            m_base[i] = 16'h0000;
            m_cfg[i]  = 1'b0;
        end
        m_rdata = 16'hFFFF;
    endtask

    task automatic wait_ack(output int cyc);
        bit seen;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 8) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (ack) seen = 1'b1;
        end
    endtask

    task automatic access(input bit is_rd, input logic [7:0] off, input logic [7:0] wd,
                          output logic [15:0] rd);
        int cyc;
        req = 1'b1; sel = 1'b1; rw = is_rd; addr = off[7:1]; wdata = wd;
        wait_ack(cyc);
        check(is_rd ? "rd_ack_latency" : "wr_ack_latency", 32'(cyc), is_rd ? 32'd3 : 32'd1);
        rd = rdata;
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ack_single_pulse", 32'(ack), 32'h0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rd;
        logic [7:0]  off;
        logic [7:0]  wd;
        logic [1:0]  e_brd;
        logic [7:0]  e_zii;
        logic [15:0] e_ziii;
        logic [15:0] e_eth;
        logic [2:0]  e_cfg;
        bit          e_done;
        logic [15:0] e_rdata;
    } vec_t;

    vec_t vt[10];

    initial begin
        logic [15:0] rd;
        logic [7:0]  off, wd;
        bit          is_rd;
        int          n_ack, cyc;

        reset_n = 1'b0; req = 1'b0; sel = 1'b0; rw = 1'b0; addr = 7'h00; wdata = 8'h00;
        zii_en = 1'b1; ziii_en = 1'b1; eth_en = 1'b1;

        vt[0] = '{1'b1, 8'h00, 8'h00, 2'd0, 8'h00, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'hEFFF};
        vt[1] = '{1'b0, 8'h4A, 8'h50, 2'd0, 8'h05, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'hEFFF};
        vt[2] = '{1'b0, 8'h48, 8'h20, 2'd1, 8'h25, 16'h0000, 16'h0000, 3'b001, 1'b0, 16'hEFFF};
        vt[3] = '{1'b1, 8'h00, 8'h00, 2'd1, 8'h25, 16'h0000, 16'h0000, 3'b001, 1'b0, 16'hAFFF};
        vt[4] = '{1'b0, 8'h44, 8'h40, ETH_BUILD ? 2'd2 : 2'd3, 8'h25, 16'h4000, 16'h0000, 3'b011, !ETH_BUILD, 16'hAFFF};
        vt[5] = '{1'b0, 8'h46, 8'h00, ETH_BUILD ? 2'd2 : 2'd3, 8'h25, 16'h4000, 16'h0000, 3'b011, !ETH_BUILD, 16'hAFFF};
        vt[6] = '{1'b0, 8'h46, 8'h12, ETH_BUILD ? 2'd2 : 2'd3, 8'h25, 16'h4000, ETH_BUILD ? 16'h0012 : 16'h0000, 3'b011, !ETH_BUILD, 16'hAFFF};
        vt[7] = '{1'b0, 8'h4C, 8'h00, 2'd3, 8'h25, 16'h4000, ETH_BUILD ? 16'h0012 : 16'h0000, 3'b011, 1'b1, 16'hAFFF};
        vt[8] = '{1'b1, 8'h04, 8'h00, 2'd3, 8'h25, 16'h4000, ETH_BUILD ? 16'h0012 : 16'h0000, 3'b011, 1'b1, 16'h3FFF};
        vt[9] = '{1'b0, 8'h48, 8'h77, 2'd3, 8'h25, 16'h4000, ETH_BUILD ? 16'h0012 : 16'h0000, 3'b011, 1'b1, 16'h3FFF};

        do_reset(1'b1, 1'b1, 1'b1);
        check("first_rom_a", 32'(rom_a), 32'h00);
        for (int i = 0; i < 10; i++) begin
            access(vt[i].rd, vt[i].off, vt[i].wd, rd);
            check($sformatf("vec%0d_rom_a", i), 32'(rom_a), 32'({vt[i].e_brd, vt[i].off[7:2]}));
            check($sformatf("vec%0d_zii_base", i), 32'(zii_base), 32'(vt[i].e_zii));
            check($sformatf("vec%0d_ziii_base", i), 32'(ziii_base), 32'(vt[i].e_ziii));
            check($sformatf("vec%0d_eth_base", i), 32'(eth_base), 32'(vt[i].e_eth));
            check($sformatf("vec%0d_cfg", i), 32'({eth_cfg, ziii_cfg, zii_cfg}), 32'(vt[i].e_cfg));
            check($sformatf("vec%0d_cfg_done", i), 32'(cfg_done), 32'(vt[i].e_done));
            check($sformatf("vec%0d_rdata", i), 32'(rdata), 32'(vt[i].e_rdata));
        end

        // Only ZIII enabled: first read addresses slot 1; its $44 write ends the chain.
        do_reset(1'b0, 1'b1, 1'b0);
        access(1'b1, 8'h00, 8'h00, rd);
        check("z3only_rom_a", 32'(rom_a), 32'h40);
        check("z3only_rdata", 32'(rd), 32'hAFFF);
        access(1'b0, 8'h44, 8'h80, rd);
        check("z3only_done", 32'(cfg_done), 32'h1);

        // ETH requested but the slot participates only in the ETH build.
        do_reset(1'b0, 1'b1, 1'b1);
        access(1'b0, 8'h44, 8'h33, rd);
        check("eth_skip_brd", 32'(rom_a[7:6]), ETH_BUILD ? 32'd2 : 32'd3);
        check("eth_skip_done", 32'(cfg_done), ETH_BUILD ? 32'd0 : 32'd1);

        // No slot enabled: chain is exhausted right after reset.
        do_reset(1'b0, 1'b0, 1'b0);
        check_model("noen");

        // Read with req held 10 cycles: one ack; re-request needs a low cycle.
        do_reset(1'b1, 1'b1, 1'b1);
        req = 1'b1; sel = 1'b1; rw = 1'b1; addr = 7'h00;
        n_ack = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (ack) n_ack++;
        end
        check("hold_one_ack", 32'(n_ack), 32'd1);
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req = 1'b1;
        wait_ack(cyc);
        check("rereq_latency", 32'(cyc), 32'd3);
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Request dropped before ack: the read still completes with exactly one ack.
        req = 1'b1; sel = 1'b1; rw = 1'b1; addr = 7'h05;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        n_ack = 0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            if (ack) n_ack++;
        end
        check("drop_one_ack", 32'(n_ack), 32'd1);
        m_rdata = {rom_fn({2'(m_brd), addr[6:1]}), 12'hFFF};
        check_model("drop");

        // Request outside the window is ignored.
        req = 1'b1; sel = 1'b0; rw = 1'b0; addr = 7'h26; wdata = 8'h00;
        n_ack = 0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (ack) n_ack++;
        end
        check("nosel_no_ack", 32'(n_ack), 32'd0);
        req = 1'b0; sel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_model("nosel");

        // Reset asserted while in RD0 aborts the read.
        access(1'b0, 8'h4A, 8'hF0, rd);
        access(1'b1, 8'h00, 8'h00, rd);
        req = 1'b1; sel = 1'b1; rw = 1'b1; addr = 7'h00;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_ack", 32'(ack), 32'h0);
        check("abort_rdata", 32'(rdata), 32'hFFFF);
        check("abort_zii_base", 32'(zii_base), 32'h0);
        check("abort_cfg_done", 32'(cfg_done), 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("abort_no_late_ack", 32'(ack), 32'h0);

        // Randomized traffic against the slot-level model.
        do_reset(1'b1, 1'b1, 1'b1);
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 14) == 0) begin
                do_reset(1'($urandom), 1'($urandom), 1'($urandom));
            end else begin
                is_rd = ($urandom_range(0, 2) == 0);
                case ($urandom_range(0, 7))
                    0: off = 8'h00;
                    1: off = 8'h44;
                    2: off = 8'h46;
                    3: off = 8'h48;
                    4: off = 8'h4A;
                    5: off = 8'h4C;
                    default: off = 8'($urandom_range(0, 127)) << 1;
                endcase
                wd = 8'($urandom);
                access(is_rd, off, wd, rd);
                if (is_rd) m_rdata = {rom_fn({2'(m_brd), off[7:2]}), 12'hFFF};
                else model_write(off, wd);
            end
            check_model("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
